// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Committed-store FIFO that drains head entries to memory through
//               a registered request/complete handshake. It also offers a
//               zero-latency load lookup against every occupied entry.
//               Optional build macro STORE_BUFFER_FORWARD_EN enables
//               byte-granular store-to-load forwarding (youngest entry wins).
//               Without the macro, any byte overlap with a buffered store is
//               reported as a conflict and nothing is forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enqueueValid,
  output logic                  enqueueReady,
  input  logic [ADDR_WIDTH-1:0] enqueueAddress,
  input  logic [DATA_WIDTH-1:0] enqueueData,
  input  logic [BE_WIDTH-1:0]   enqueueByteEnable,
  input  logic                  loadValid,
  input  logic [ADDR_WIDTH-1:0] loadAddress,
  input  logic [BE_WIDTH-1:0]   loadByteEnable,
  output logic                  loadHit,
  output logic                  loadConflict,
  output logic [DATA_WIDTH-1:0] loadData,
  output logic                  storeValid,
  output logic [ADDR_WIDTH-1:0] storeAddress,
  output logic [DATA_WIDTH-1:0] storeData,
  output logic [BE_WIDTH-1:0]   storeByteEnable,
  input  logic                  storeComplete,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  localparam int PW  = $clog2(DEPTH);
  localparam int OFF = $clog2(BE_WIDTH);

  // Entry storage (payload is not reset; occupancy is tracked by r_valid)
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [BE_WIDTH-1:0]   r_be   [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_store_valid;

  logic                  w_enq;
  logic                  w_retire;
  logic                  w_full;

  // Age-ordered view: slot k is the k-th oldest position from the head
  logic [PW-1:0]         w_idx   [DEPTH];
  logic [DEPTH-1:0]      w_match;
  logic [BE_WIDTH-1:0]   w_cover;
  logic                  w_any;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_enq    = enqueueValid && !w_full;
  assign w_retire = r_store_valid && storeComplete;

  // Pointer, occupancy, count and drain-request state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_valid       <= '0;
      r_store_valid <= 1'b0;
    end else begin
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= ptr_inc(r_tail);
      end
      case ({w_enq, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Request drops on completion and re-arms on the following edge at the
      // earliest, which yields one idle cycle between consecutive requests.
      if (r_store_valid) begin
        if (storeComplete) begin
          r_store_valid <= 1'b0;
        end
      end else if (r_count != '0) begin
        r_store_valid <= 1'b1;
      end
    end
  end

  // Payload write at the tail slot
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_addr[r_tail] <= enqueueAddress;
      r_data[r_tail] <= enqueueData;
      r_be[r_tail]   <= enqueueByteEnable;
    end
  end

  // Per-age-slot address match against the load word address
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign w_idx[g]   = r_head + PW'(g);
    assign w_match[g] = r_valid[w_idx[g]] &&
                        (r_addr[w_idx[g]][ADDR_WIDTH-1:OFF] == loadAddress[ADDR_WIDTH-1:OFF]);
  end

  if (OFF > 0) begin : g_offset_unused
    logic w_unused_load_offset;
    assign w_unused_load_offset = ^loadAddress[OFF-1:0];
  end

  // Requested bytes that some occupied matching entry also writes
  always_comb begin
    w_cover = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        w_cover = w_cover | (r_be[w_idx[k]] & loadByteEnable);
      end
    end
  end

  assign w_any = |w_cover;

`ifdef STORE_BUFFER_FORWARD_EN
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic                  w_all;

  // Scan oldest to youngest so the youngest writer of each byte wins
  always_comb begin
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (r_be[w_idx[k]][b] && loadByteEnable[b]) begin
            w_fwd_data[b*8 +: 8] = r_data[w_idx[k]][b*8 +: 8];
          end
        end
      end
    end
  end

  assign w_all        = (w_cover == loadByteEnable);
  assign loadHit      = loadValid && w_any && w_all;
  assign loadConflict = loadValid && w_any && !w_all;
  assign loadData     = loadHit ? w_fwd_data : '0;
`else
  assign loadHit      = 1'b0;
  assign loadConflict = loadValid && w_any;
  assign loadData     = '0;
`endif

  assign enqueueReady    = !w_full;
  assign storeValid      = r_store_valid;
  assign storeAddress    = r_addr[r_head];
  assign storeData       = r_data[r_head];
  assign storeByteEnable = r_be[r_head];
  assign count           = r_count;
  assign empty           = (r_count == '0);
  assign full            = w_full;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer; a scoreboard queue holds
//               accepted stores and is compared against the drained head.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enqueueValid = 1'b0;
  logic          enqueueReady;
  logic [31:0]   enqueueAddress = '0;
  logic [31:0]   enqueueData = '0;
  logic [3:0]    enqueueByteEnable = '0;
  logic          loadValid = 1'b0;
  logic [31:0]   loadAddress = '0;
  logic [3:0]    loadByteEnable = '0;
  logic          loadHit;
  logic          loadConflict;
  logic [31:0]   loadData;
  logic          storeValid;
  logic [31:0]   storeAddress;
  logic [31:0]   storeData;
  logic [3:0]    storeByteEnable;
  logic          storeComplete = 1'b0;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  st_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .enqueueValid(enqueueValid), .enqueueReady(enqueueReady),
    .enqueueAddress(enqueueAddress), .enqueueData(enqueueData),
    .enqueueByteEnable(enqueueByteEnable),
    .loadValid(loadValid), .loadAddress(loadAddress), .loadByteEnable(loadByteEnable),
    .loadHit(loadHit), .loadConflict(loadConflict), .loadData(loadData),
    .storeValid(storeValid), .storeAddress(storeAddress), .storeData(storeData),
    .storeByteEnable(storeByteEnable), .storeComplete(storeComplete),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one store for one edge; the model accepts it when it holds < DEPTH
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_t e;
    enqueueValid = 1'b1; enqueueAddress = a; enqueueData = d; enqueueByteEnable = be;
    e = '{addr: a, data: d, be: be};
    if (sb.size() < DEPTH) sb.push_back(e);
    tick();
    enqueueValid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if ({empty, full, enqueueReady, storeValid} !== 4'b1010)
      $display("FAIL reset_flags: got e/f/r/sv=%b want 1010", {empty, full, enqueueReady, storeValid}); else n_pass++;
    loadValid = 1'b1; loadAddress = 32'h100; loadByteEnable = 4'hF; #1;
    n_checks++; if ({loadHit, loadConflict} !== 2'b00)
      $display("FAIL reset_load: got hit/conf=%b want 00", {loadHit, loadConflict}); else n_pass++;
    loadValid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    st_t e;
    push_store(32'h100, 32'hDEADBEEF, 4'hF);
    n_checks++; if (count !== 3'd1) $display("FAIL single_count1: got %0d want 1", count); else n_pass++;
    n_checks++; if (storeValid !== 1'b0) $display("FAIL single_sv_early: got %b want 0", storeValid); else n_pass++;
    // completion while no request is pending must be ignored
    storeComplete = 1'b1;
    tick();
    n_checks++; if (storeValid !== 1'b1) $display("FAIL single_sv_rise: got %b want 1", storeValid); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("FAIL single_ignored_complete: got count %0d want 1", count); else n_pass++;
    e = sb.pop_front();
    n_checks++; if ({storeAddress, storeData, storeByteEnable} !== e)
      $display("FAIL single_head: got %h want %h", {storeAddress, storeData, storeByteEnable}, e); else n_pass++;
    tick();
    storeComplete = 1'b0;
    n_checks++; if ({storeValid, count, empty} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL single_retire: got sv/count/empty=%b/%0d/%b want 0/0/1", storeValid, count, empty); else n_pass++;
  endtask

  task automatic test_full();
    st_t e;
    for (int i = 0; i < 4; i++) push_store(32'h400 + 32'(i * 4), $urandom, 4'hF);
    n_checks++; if ({full, enqueueReady, count} !== {1'b1, 1'b0, 3'd4})
      $display("FAIL full_flags: got full/ready/count=%b/%b/%0d want 1/0/4", full, enqueueReady, count); else n_pass++;
    push_store(32'h999C, 32'h99999999, 4'hF);
    n_checks++; if (count !== 3'd4) $display("FAIL full_fifth_ignored: got %0d want 4", count); else n_pass++;
    n_checks++; if (storeValid !== 1'b1) $display("FAIL full_sv: got %b want 1", storeValid); else n_pass++;
    e = sb.pop_front();
    n_checks++; if ({storeAddress, storeData, storeByteEnable} !== e)
      $display("FAIL full_head: got %h want %h", {storeAddress, storeData, storeByteEnable}, e); else n_pass++;
    enqueueValid = 1'b1; enqueueAddress = 32'h500; enqueueData = 32'hCAFEF00D; enqueueByteEnable = 4'hF;
    storeComplete = 1'b1;
    #1;
    n_checks++; if (enqueueReady !== 1'b0) $display("FAIL full_ready_with_complete: got %b want 0", enqueueReady); else n_pass++;
    tick();
    storeComplete = 1'b0;
    n_checks++; if ({count, storeValid} !== {3'd3, 1'b0})
      $display("FAIL full_retire_cycle: got count/sv=%0d/%b want 3/0", count, storeValid); else n_pass++;
    sb.push_back('{addr: 32'h500, data: 32'hCAFEF00D, be: 4'hF});
    tick();
    enqueueValid = 1'b0;
    n_checks++; if (count !== 3'd4) $display("FAIL full_refill: got %0d want 4", count); else n_pass++;
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 8 && !storeValid; w++) tick();
      n_checks++;
      if (storeValid !== 1'b1) $display("FAIL full_drain_timeout: got sv %b want 1", storeValid);
      else begin
        e = sb.pop_front();
        if ({storeAddress, storeData, storeByteEnable} !== e)
          $display("FAIL full_drain_head: got %h want %h", {storeAddress, storeData, storeByteEnable}, e);
        else n_pass++;
      end
      storeComplete = 1'b1; tick(); storeComplete = 1'b0;
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL full_drained_empty: got %b want 1", empty); else n_pass++;
    sb.delete();
  endtask

  task automatic test_forward();
    st_t e;
    // lookup in the same cycle as the enqueue must not see the new entry
    enqueueValid = 1'b1; enqueueAddress = 32'h200; enqueueData = 32'h11223344; enqueueByteEnable = 4'hF;
    loadValid = 1'b1; loadAddress = 32'h200; loadByteEnable = 4'hF;
    #1;
    n_checks++; if ({loadHit, loadConflict} !== 2'b00)
      $display("FAIL fwd_same_cycle: got hit/conf=%b want 00", {loadHit, loadConflict}); else n_pass++;
    sb.push_back('{addr: 32'h200, data: 32'h11223344, be: 4'hF});
    tick();
    enqueueValid = 1'b0;
    #1;
    n_checks++; if ({loadHit, loadConflict, loadData} !== {FWD, !FWD, FWD ? 32'h11223344 : 32'h0})
      $display("FAIL fwd_visible: got hit/conf/data=%b/%b/%h", loadHit, loadConflict, loadData); else n_pass++;
    push_store(32'h200, 32'h000000AA, 4'h1);
    #1;
    n_checks++; if ({loadHit, loadConflict, loadData} !== {FWD, !FWD, FWD ? 32'h112233AA : 32'h0})
      $display("FAIL fwd_youngest: got hit/conf/data=%b/%b/%h want %b/%b/%h", loadHit, loadConflict, loadData,
               FWD, !FWD, FWD ? 32'h112233AA : 32'h0); else n_pass++;
    loadAddress = 32'h203; loadByteEnable = 4'h1; #1;
    n_checks++; if ({loadHit, loadConflict, loadData} !== {FWD, !FWD, FWD ? 32'h000000AA : 32'h0})
      $display("FAIL fwd_byte0_offset: got hit/conf/data=%b/%b/%h", loadHit, loadConflict, loadData); else n_pass++;
    loadAddress = 32'h204; loadByteEnable = 4'hF; #1;
    n_checks++; if ({loadHit, loadConflict, loadData} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL fwd_other_word: got hit/conf/data=%b/%b/%h want 0/0/0", loadHit, loadConflict, loadData); else n_pass++;
    loadValid = 1'b0; loadAddress = 32'h200; #1;
    n_checks++; if ({loadHit, loadConflict} !== 2'b00)
      $display("FAIL fwd_no_valid: got hit/conf=%b want 00", {loadHit, loadConflict}); else n_pass++;
    for (int n = 0; n < 2; n++) begin
      for (int w = 0; w < 8 && !storeValid; w++) tick();
      n_checks++;
      if (storeValid !== 1'b1) $display("FAIL fwd_drain_timeout: got sv %b want 1", storeValid);
      else begin
        e = sb.pop_front();
        if ({storeAddress, storeData, storeByteEnable} !== e)
          $display("FAIL fwd_drain_head: got %h want %h", {storeAddress, storeData, storeByteEnable}, e);
        else n_pass++;
      end
      storeComplete = 1'b1; tick(); storeComplete = 1'b0;
    end
    sb.delete();
  endtask

  task automatic test_partial();
    st_t e;
    push_store(32'h300, 32'h0000BEEF, 4'h3);
    loadValid = 1'b1; loadAddress = 32'h300; loadByteEnable = 4'hF; #1;
    n_checks++; if ({loadHit, loadConflict, loadData} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL part_conflict: got hit/conf/data=%b/%b/%h want 0/1/0", loadHit, loadConflict, loadData); else n_pass++;
    loadByteEnable = 4'h3; #1;
    n_checks++; if ({loadHit, loadConflict, loadData} !== {FWD, !FWD, FWD ? 32'h0000BEEF : 32'h0})
      $display("FAIL part_exact: got hit/conf/data=%b/%b/%h", loadHit, loadConflict, loadData); else n_pass++;
    loadByteEnable = 4'hC; #1;
    n_checks++; if ({loadHit, loadConflict} !== 2'b00)
      $display("FAIL part_disjoint: got hit/conf=%b want 00", {loadHit, loadConflict}); else n_pass++;
    loadByteEnable = 4'hF;
    for (int w = 0; w < 8 && !storeValid; w++) tick();
    n_checks++;
    if (storeValid !== 1'b1) $display("FAIL part_sv_timeout: got %b want 1", storeValid);
    else begin
      e = sb.pop_front();
      if ({storeAddress, storeData, storeByteEnable} !== e)
        $display("FAIL part_head: got %h want %h", {storeAddress, storeData, storeByteEnable}, e);
      else n_pass++;
    end
    storeComplete = 1'b1; #1;
    n_checks++; if (loadConflict !== 1'b1) $display("FAIL part_before_retire: got conf %b want 1", loadConflict); else n_pass++;
    tick();
    storeComplete = 1'b0;
    n_checks++; if ({loadHit, loadConflict} !== 2'b00)
      $display("FAIL part_after_retire: got hit/conf=%b want 00", {loadHit, loadConflict}); else n_pass++;
    loadValid = 1'b0;
    sb.delete();
  endtask

  task automatic test_back_to_back();
    st_t e;
    int  pulses = 0;
    bit  prev_sv = 1'b0;
    for (int i = 0; i < 3; i++) push_store(32'h700 + 32'(i * 4), $urandom, 4'(i + 5));
    storeComplete = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (storeValid) begin
        pulses++;
        n_checks++;
        if (prev_sv) $display("FAIL b2b_spacing: got sv high two cycles in a row want idle gap");
        else if (sb.size() == 0) $display("FAIL b2b_extra: got sv=1 want no pending store");
        else begin
          e = sb.pop_front();
          if ({storeAddress, storeData, storeByteEnable} !== e)
            $display("FAIL b2b_head: got %h want %h", {storeAddress, storeData, storeByteEnable}, e);
          else n_pass++;
        end
      end
      prev_sv = storeValid;
      tick();
    end
    storeComplete = 1'b0;
    n_checks++; if (pulses !== 3) $display("FAIL b2b_pulses: got %0d want 3", pulses); else n_pass++;
    n_checks++; if ({empty, count} !== {1'b1, 3'd0})
      $display("FAIL b2b_empty: got empty/count=%b/%0d want 1/0", empty, count); else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_store(32'h600 + 32'(i * 4), $urandom, 4'hF);
    n_checks++; if ({storeValid, count} !== {1'b1, 3'd3})
      $display("FAIL rmid_pre: got sv/count=%b/%0d want 1/3", storeValid, count); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if ({storeValid, count, empty, full, enqueueReady} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b1})
      $display("FAIL rmid_async: got sv/count/e/f/r=%b/%0d/%b/%b/%b want 0/0/1/0/1",
               storeValid, count, empty, full, enqueueReady); else n_pass++;
    loadValid = 1'b1; loadAddress = 32'h600; loadByteEnable = 4'hF; #1;
    n_checks++; if ({loadHit, loadConflict} !== 2'b00)
      $display("FAIL rmid_load: got hit/conf=%b want 00", {loadHit, loadConflict}); else n_pass++;
    loadValid = 1'b0;
    sb.delete();
    tick();
    reset = 1'b0;
    tick(); tick();
    n_checks++; if ({storeValid, count} !== {1'b0, 3'd0})
      $display("FAIL rmid_discarded: got sv/count=%b/%0d want 0/0", storeValid, count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t want completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
